// File: rtl/led_pattern_gen.sv
// LED pattern generator: divides the system clock into a slow tick and drives one
// registered LED output with an off, blink, PWM breathe or heartbeat pattern.
module led_pattern_gen #(
  parameter int TICK_DIV    = 12000,
  parameter int BLINK_TICKS = 500,
  parameter int STEP        = 4,
  parameter int HB_ON       = 100,
  parameter int HB_REST     = 700
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  output logic       led,
  output logic       tick,
  output logic [7:0] duty
);

  localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PH_MAX = (BLINK_TICKS > HB_ON)
                          ? ((BLINK_TICKS > HB_REST) ? BLINK_TICKS : HB_REST)
                          : ((HB_ON > HB_REST) ? HB_ON : HB_REST);
  localparam int PH_W   = $clog2(PH_MAX + 1);

  localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(TICK_DIV - 1);
  localparam logic [PH_W-1:0]  BLINK_LAST = PH_W'(BLINK_TICKS - 1);
  localparam logic [PH_W-1:0]  HB_ON_LAST = PH_W'(HB_ON - 1);
  localparam logic [PH_W-1:0]  HB_RS_LAST = PH_W'(HB_REST - 1);
  localparam logic [7:0]       STEP8      = 8'(STEP);
  localparam logic [7:0]       UP_LIMIT   = 8'(255 - STEP);

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_BLINK   = 2'b01;
  localparam logic [1:0] MODE_BREATHE = 2'b10;
  localparam logic [1:0] MODE_HEART   = 2'b11;

  typedef enum logic {
    DIR_UP,
    DIR_DOWN
  } dir_t;

  typedef enum logic [1:0] {
    S_BEAT1,
    S_GAP,
    S_BEAT2,
    S_REST
  } hb_t;

  logic [1:0]       r_mode_q;
  logic [PRE_W-1:0] r_pre_cnt;
  logic [PH_W-1:0]  r_phase;
  logic [7:0]       r_duty;
  logic [7:0]       r_pwm_cnt;
  logic             r_blink_q;
  logic             r_led;
  dir_t             r_dir;
  hb_t              r_hb_state;

  logic [1:0]       w_mode_nxt;
  logic [PRE_W-1:0] w_pre_nxt;
  logic [PH_W-1:0]  w_phase_nxt;
  logic [7:0]       w_duty_nxt;
  logic             w_blink_nxt;
  logic             w_led_nxt;
  dir_t             w_dir_nxt;
  hb_t              w_hb_nxt;
  logic             w_tick;
  logic [PH_W-1:0]  w_hb_last;

  assign w_tick    = (r_pre_cnt == PRE_LAST);
  assign w_hb_last = (r_hb_state == S_REST) ? HB_RS_LAST : HB_ON_LAST;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_q   <= MODE_OFF;
      r_pre_cnt  <= '0;
      r_phase    <= '0;
      r_duty     <= '0;
      r_pwm_cnt  <= '0;
      r_blink_q  <= 1'b0;
      r_led      <= 1'b0;
      r_dir      <= DIR_UP;
      r_hb_state <= S_BEAT1;
    end else begin
      r_mode_q   <= w_mode_nxt;
      r_pre_cnt  <= w_pre_nxt;
      r_phase    <= w_phase_nxt;
      r_duty     <= w_duty_nxt;
      r_pwm_cnt  <= r_pwm_cnt + 8'd1;
      r_blink_q  <= w_blink_nxt;
      r_led      <= w_led_nxt;
      r_dir      <= w_dir_nxt;
      r_hb_state <= w_hb_nxt;
    end
  end

  always_comb begin
    w_mode_nxt  = r_mode_q;
    w_pre_nxt   = w_tick ? '0 : r_pre_cnt + PRE_W'(1);
    w_phase_nxt = r_phase;
    w_duty_nxt  = r_duty;
    w_blink_nxt = r_blink_q;
    w_dir_nxt   = r_dir;
    w_hb_nxt    = r_hb_state;

    // A mode change restarts everything and swallows a coincident tick.
    if (mode != r_mode_q) begin
      w_mode_nxt  = mode;
      w_pre_nxt   = '0;
      w_phase_nxt = '0;
      w_duty_nxt  = '0;
      w_blink_nxt = 1'b0;
      w_dir_nxt   = DIR_UP;
      w_hb_nxt    = S_BEAT1;
    end else if (w_tick) begin
      case (r_mode_q)
        MODE_BLINK: begin
          if (r_phase == BLINK_LAST) begin
            w_phase_nxt = '0;
            w_blink_nxt = ~r_blink_q;
          end else begin
            w_phase_nxt = r_phase + PH_W'(1);
          end
        end
        MODE_BREATHE: begin
          if (r_dir == DIR_UP) begin
            if (r_duty > UP_LIMIT) begin
              w_duty_nxt = 8'd255;
              w_dir_nxt  = DIR_DOWN;
            end else begin
              w_duty_nxt = r_duty + STEP8;
            end
          end else begin
            if (r_duty < STEP8) begin
              w_duty_nxt = 8'd0;
              w_dir_nxt  = DIR_UP;
            end else begin
              w_duty_nxt = r_duty - STEP8;
            end
          end
        end
        MODE_HEART: begin
          if (r_phase == w_hb_last) begin
            w_phase_nxt = '0;
            case (r_hb_state)
              S_BEAT1: w_hb_nxt = S_GAP;
              S_GAP:   w_hb_nxt = S_BEAT2;
              S_BEAT2: w_hb_nxt = S_REST;
              default: w_hb_nxt = S_BEAT1;
            endcase
          end else begin
            w_phase_nxt = r_phase + PH_W'(1);
          end
        end
        default: ;
      endcase
    end

    case (r_mode_q)
      MODE_BLINK:   w_led_nxt = r_blink_q;
      MODE_BREATHE: w_led_nxt = (r_pwm_cnt < r_duty);
      MODE_HEART:   w_led_nxt = (r_hb_state == S_BEAT1) || (r_hb_state == S_BEAT2);
      default:      w_led_nxt = 1'b0;
    endcase
  end

  assign led  = r_led;
  assign tick = w_tick;
  assign duty = r_duty;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: a tick-count reference model predicts led/tick/duty
// for every clock into a queue; a monitor pops and compares each cycle.
module tb_led_pattern_gen;

  localparam int TD    = 4;
  localparam int BT    = 3;
  localparam int ST    = 64;
  localparam int HON   = 2;
  localparam int HREST = 5;
  localparam int HPER  = 3 * HON + HREST;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] mode = 2'b00;
  logic       led;
  logic       tick;
  logic [7:0] duty;

  led_pattern_gen #(
    .TICK_DIV   (TD),
    .BLINK_TICKS(BT),
    .STEP       (ST),
    .HB_ON      (HON),
    .HB_REST    (HREST)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .mode (mode),
    .led  (led),
    .tick (tick),
    .duty (duty)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [9:0] exp_q[$];
  logic [9:0] mon_exp;
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         chk_en = 1'b0;
  bit         ramp_en = 1'b0;
  int         ramp_idx = 0;
  logic [7:0] prev_duty = 8'd0;
  int         ramp_tbl[9] = '{64, 128, 192, 255, 191, 127, 63, 0, 64};

  // ---------------- reference model ----------------
  // Patterns are derived from the number of ticks since the last restart.
  int m_mode_q, m_pre, m_k, m_duty, m_pwm;
  bit m_up, m_led_cur;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit hb_led(input int k);
    int p;
    p = k % HPER;
    return (p < HON) || (p >= 2 * HON && p < 3 * HON);
  endfunction

  task automatic model_reset();
    m_mode_q  = 0;
    m_pre     = 0;
    m_k       = 0;
    m_duty    = 0;
    m_pwm     = 0;
    m_up      = 1'b1;
    m_led_cur = 1'b0;
  endtask

  // Drive one cycle's input and predict the outputs seen after the next edge.
  task automatic cycle(input logic [1:0] m);
    bit l;
    bit t;
    mode = m;
    case (m_mode_q)
      1:       l = ((m_k / BT) % 2) == 1;
      2:       l = (m_pwm < m_duty);
      3:       l = hb_led(m_k);
      default: l = 1'b0;
    endcase
    t = (m_pre == TD - 1);
    if (int'(m) != m_mode_q) begin
      m_mode_q = int'(m);
      m_pre    = 0;
      m_k      = 0;
      m_duty   = 0;
      m_up     = 1'b1;
    end else begin
      if (t && m_mode_q != 0) begin
        m_k++;
        if (m_mode_q == 2) begin
          if (m_up) begin
            if (m_duty > 255 - ST) begin m_duty = 255; m_up = 1'b0; end
            else m_duty += ST;
          end else begin
            if (m_duty < ST) begin m_duty = 0; m_up = 1'b1; end
            else m_duty -= ST;
          end
        end
      end
      m_pre = t ? 0 : m_pre + 1;
    end
    m_pwm     = (m_pwm + 1) % 256;
    m_led_cur = l;
    exp_q.push_back({l, (m_pre == TD - 1), 8'(m_duty)});
  endtask

  // ---------------- driver tasks (each starts and ends at a negedge) ----------------
  task automatic run(input logic [1:0] m, input int n);
    for (int i = 0; i < n; i++) begin
      cycle(m);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_led", 32'(led), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_duty", 32'(duty), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic tick_switch(input logic [1:0] old_m, input logic [1:0] new_m);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 2 * TD; i++) begin
      if (m_pre == TD - 1) begin
        hit = 1'b1;
        break;
      end
      cycle(old_m);
      @(negedge clk);
    end
    if (hit) begin
      check("tick_align", 32'(tick), 32'd1);
      cycle(new_m);
      @(negedge clk);
    end else begin
      n_cmp++;
      n_bad++;
      $display("FAIL tick_wait: no tick cycle found, got none expected one within %0d", 2 * TD);
    end
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    #1;
    if (chk_en && rst_n) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL underflow: got output with no expected entry at %0t", $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("led_tick_duty", 32'({led, tick, duty}), 32'(mon_exp));
      end
      if (ramp_en && duty !== prev_duty && ramp_idx < 9) begin
        check("ramp", 32'(duty), 32'(ramp_tbl[ramp_idx]));
        ramp_idx++;
      end
      prev_duty = duty;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit found;
    logic [1:0] nm;
    model_reset();
    @(negedge clk);
    do_reset();
    chk_en = 1'b1;

    run(2'b00, 100);

    do_reset();
    run(2'b01, 60);

    ramp_en  = 1'b1;
    ramp_idx = 0;
    run(2'b10, 40);
    ramp_en = 1'b0;
    check("ramp_len", 32'(ramp_idx), 32'd9);
    run(2'b10, 300);

    tick_switch(2'b10, 2'b01);
    run(2'b01, 60);

    run(2'b11, 100);

    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (m_mode_q == 3 && (m_k % HPER) >= 2 * HON && (m_k % HPER) < 3 * HON && m_led_cur) begin
        found = 1'b1;
        break;
      end
      cycle(2'b11);
      @(negedge clk);
    end
    check("beat2_found", 32'(found), 32'd1);
    check("beat2_led", 32'(led), 32'd1);
    do_reset();
    run(2'b11, 100);

    for (int s = 0; s < 25; s++) begin
      nm = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) tick_switch(mode, nm);
      run(nm, $urandom_range(5, 80));
    end

    check("drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
